// File: rtl/clock_pkg.sv
// Calendar constants, month table and FSM state encoding shared by the
// BCD-to-unix-seconds encoder.
package clock_pkg;

  localparam logic [13:0] EPOCH_YEAR   = 14'd1970;
  localparam logic [13:0] YEAR_MAX     = 14'd2099;
  localparam logic [31:0] SECS_PER_DAY = 32'd86400;

  localparam logic [4:0] DAYS_IN_MONTH [12] = '{
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
  };

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CHECK   = 3'd1;
  localparam state_t ST_YEARS   = 3'd2;
  localparam state_t ST_MONTHS  = 3'd3;
  localparam state_t ST_COMBINE = 3'd4;

  // Returns 0 for an out-of-range month so callers can use it as a validity bound.
  function automatic logic [4:0] days_in_month(input logic [6:0] month, input logic leap);
    logic [4:0] d;
    logic [3:0] idx;
    d   = 5'd0;
    idx = month[3:0] - 4'd1;
    if (month >= 7'd1 && month <= 7'd12) begin
      d = DAYS_IN_MONTH[idx];
      if (month == 7'd2 && leap) d = 5'd29;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd2_to_bin.sv
// Two-digit packed BCD to binary; valid drops when either nibble exceeds 9.
module bcd2_to_bin (
  input  logic [7:0] bcd,
  output logic [6:0] bin,
  output logic       valid
);

  always_comb begin
    valid = (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
    bin   = {3'b000, bcd[7:4]} * 7'd10 + {3'b000, bcd[3:0]};
  end

endmodule

// File: rtl/bcd_to_unix_encoder.sv
// Iterative BCD calendar date/time to unix-seconds encoder (one year or month per clock).
// Optional active-low load pulse output enabled by macro BCD_ENC_LOAD_PULSE_EN.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for start; inputs captured on the accepting edge
// ST_CHECK   | BCD decode and range validation of captured fields
// ST_YEARS   | add 365/366 per elapsed year since 1970
// ST_MONTHS  | add days of each elapsed month of the target year
// ST_COMBINE | fold days, day-of-month and h/m/s into seconds, pulse done
module bcd_to_unix_encoder
  import clock_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  year_bcd_in,
  input  logic [7:0]   month_bcd_in,
  input  logic [7:0]   day_bcd_in,
  input  logic [7:0]   hour_bcd_in,
  input  logic [7:0]   minute_bcd_in,
  input  logic [7:0]   second_bcd_in,
  output logic         busy,
  output logic         done,
  output logic         error,
`ifdef BCD_ENC_LOAD_PULSE_EN
  output logic         load_n,
`endif
  output logic [N-1:0] unix_time
);

  state_t         state_q, state_d;
  logic [15:0]    year_bcd_q, year_bcd_d;
  logic [7:0]     month_bcd_q, month_bcd_d, day_bcd_q, day_bcd_d;
  logic [7:0]     hour_bcd_q, hour_bcd_d, minute_bcd_q, minute_bcd_d;
  logic [7:0]     second_bcd_q, second_bcd_d;
  logic [15:0]    days_q, days_d;
  logic [1:0]     yphase_q, yphase_d;
  logic [7:0]     yrs_left_q, yrs_left_d;
  logic [6:0]     m_q, m_d;
  logic [3:0]     mons_left_q, mons_left_d;
  logic           done_q, done_d, error_q, error_d;
  logic [N-1:0]   unix_time_q, unix_time_d;

  logic [6:0]     yh_bin, yl_bin, month_bin, day_bin, hour_bin, minute_bin, second_bin;
  logic [6:0]     fv;
  logic [13:0]    year_bin;
  logic           year_leap, fields_ok;
  logic [31:0]    day_total, secs_total;

  bcd2_to_bin u_yh  (.bcd(year_bcd_q[15:8]), .bin(yh_bin),     .valid(fv[0]));
  bcd2_to_bin u_yl  (.bcd(year_bcd_q[7:0]),  .bin(yl_bin),     .valid(fv[1]));
  bcd2_to_bin u_mon (.bcd(month_bcd_q),      .bin(month_bin),  .valid(fv[2]));
  bcd2_to_bin u_day (.bcd(day_bcd_q),        .bin(day_bin),    .valid(fv[3]));
  bcd2_to_bin u_hr  (.bcd(hour_bcd_q),       .bin(hour_bin),   .valid(fv[4]));
  bcd2_to_bin u_min (.bcd(minute_bcd_q),     .bin(minute_bin), .valid(fv[5]));
  bcd2_to_bin u_sec (.bcd(second_bcd_q),     .bin(second_bin), .valid(fv[6]));

  // 14-bit year so that e.g. "6066" cannot alias into the accepted range.
  always_comb begin
    year_bin   = {7'b0, yh_bin} * 14'd100 + {7'b0, yl_bin};
    year_leap  = (year_bin[1:0] == 2'b00);
    fields_ok  = (&fv)
              && (year_bin >= EPOCH_YEAR) && (year_bin <= YEAR_MAX)
              && (month_bin >= 7'd1) && (month_bin <= 7'd12)
              && (day_bin >= 7'd1) && (day_bin <= {2'b00, days_in_month(month_bin, year_leap)})
              && (hour_bin <= 7'd23) && (minute_bin <= 7'd59) && (second_bin <= 7'd59);
    day_total  = 32'(days_q) + 32'(day_bin) - 32'd1;
    secs_total = day_total * SECS_PER_DAY + 32'(hour_bin) * 32'd3600
               + 32'(minute_bin) * 32'd60 + 32'(second_bin);
  end

  always_comb begin
    state_d      = state_q;
    year_bcd_d   = year_bcd_q;
    month_bcd_d  = month_bcd_q;
    day_bcd_d    = day_bcd_q;
    hour_bcd_d   = hour_bcd_q;
    minute_bcd_d = minute_bcd_q;
    second_bcd_d = second_bcd_q;
    days_d       = days_q;
    yphase_d     = yphase_q;
    yrs_left_d   = yrs_left_q;
    m_d          = m_q;
    mons_left_d  = mons_left_q;
    done_d       = 1'b0;
    error_d      = error_q;
    unix_time_d  = unix_time_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          year_bcd_d   = year_bcd_in;
          month_bcd_d  = month_bcd_in;
          day_bcd_d    = day_bcd_in;
          hour_bcd_d   = hour_bcd_in;
          minute_bcd_d = minute_bcd_in;
          second_bcd_d = second_bcd_in;
          state_d      = ST_CHECK;
        end
      end
      ST_CHECK: begin
        days_d      = 16'd0;
        yphase_d    = 2'd2;
        m_d         = 7'd1;
        yrs_left_d  = 8'(year_bin - EPOCH_YEAR);
        mons_left_d = month_bin[3:0] - 4'd1;
        if (!fields_ok) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (year_bin != EPOCH_YEAR) begin
          state_d = ST_YEARS;
        end else if (month_bin != 7'd1) begin
          state_d = ST_MONTHS;
        end else begin
          state_d = ST_COMBINE;
        end
      end
      ST_YEARS: begin
        // yphase tracks y%4, starting from 1970%4 == 2
        days_d     = days_q + ((yphase_q == 2'd0) ? 16'd366 : 16'd365);
        yphase_d   = yphase_q + 2'd1;
        yrs_left_d = yrs_left_q - 8'd1;
        if (yrs_left_q == 8'd1) state_d = (mons_left_q != 4'd0) ? ST_MONTHS : ST_COMBINE;
      end
      ST_MONTHS: begin
        days_d      = days_q + 16'(days_in_month(m_q, year_leap));
        m_d         = m_q + 7'd1;
        mons_left_d = mons_left_q - 4'd1;
        if (mons_left_q == 4'd1) state_d = ST_COMBINE;
      end
      ST_COMBINE: begin
        unix_time_d = N'(secs_total);
        done_d      = 1'b1;
        error_d     = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      year_bcd_q   <= 16'h0;
      month_bcd_q  <= 8'h0;
      day_bcd_q    <= 8'h0;
      hour_bcd_q   <= 8'h0;
      minute_bcd_q <= 8'h0;
      second_bcd_q <= 8'h0;
      days_q       <= 16'd0;
      yphase_q     <= 2'd0;
      yrs_left_q   <= 8'd0;
      m_q          <= 7'd0;
      mons_left_q  <= 4'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      unix_time_q  <= '0;
    end else begin
      state_q      <= state_d;
      year_bcd_q   <= year_bcd_d;
      month_bcd_q  <= month_bcd_d;
      day_bcd_q    <= day_bcd_d;
      hour_bcd_q   <= hour_bcd_d;
      minute_bcd_q <= minute_bcd_d;
      second_bcd_q <= second_bcd_d;
      days_q       <= days_d;
      yphase_q     <= yphase_d;
      yrs_left_q   <= yrs_left_d;
      m_q          <= m_d;
      mons_left_q  <= mons_left_d;
      done_q       <= done_d;
      error_q      <= error_d;
      unix_time_q  <= unix_time_d;
    end
  end

`ifdef BCD_ENC_LOAD_PULSE_EN
  logic load_n_q, load_n_d;

  // Only COMBINE produces an error-free done, so the load strobe tracks leaving it.
  always_comb load_n_d = (state_q != ST_COMBINE);

  always_ff @(posedge clk) begin
    if (!rst_n) load_n_q <= 1'b1;
    else        load_n_q <= load_n_d;
  end

  assign load_n = load_n_q;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign unix_time = unix_time_q;

endmodule

// File: doc/bcd_to_unix_encoder.md
Name: bcd_to_unix_encoder

Overview:
- Converts a BCD calendar date/time (year, month, day, hour, minute, second) into seconds since 1970-01-01 00:00:00.
- Produces the load value for the unix seconds counter when the user sets the clock. It is the writer counterpart of the counter-to-BCD display path.
- Iterative and multi-cycle: one year or one month is accumulated per clock.
- Flags invalid input instead of loading a garbage time.

Parameters:
N, 64, width of unix_time output (must be >= 32)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  request conversion; sampled only in IDLE
year_bcd_in  input  16  4-digit BCD year
month_bcd_in  input  8  2-digit BCD month
day_bcd_in  input  8  2-digit BCD day
hour_bcd_in  input  8  2-digit BCD hour
minute_bcd_in  input  8  2-digit BCD minute
second_bcd_in  input  8  2-digit BCD second
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle completion pulse
error  output  1  qualifies done; 1 = input rejected
unix_time  output  N  last valid result, held

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; busy=0, done=0, error=0, unix_time=0. Reset mid-operation aborts the conversion with no done pulse.
- Inputs are captured on the edge that samples start=1 in IDLE. Later input changes have no effect on that conversion. start while busy is ignored, not queued.
- FSM states: IDLE -> CHECK -> YEARS -> MONTHS -> COMBINE -> IDLE.
- CHECK (1 cycle): converts BCD to binary and validates the captured fields.
  - Any nibble > 9 is invalid.
  - Valid ranges: year 1970..2099, month 1..12, day 1..days_in_month, hour 0..23, minute 0..59, second 0..59.
  - Feb has 29 days when year%4==0; this rule is exact within 1970..2099.
  - On any violation, return to IDLE and pulse done=1 with error=1. unix_time is unchanged.
- YEARS: the day accumulator starts at 0. Iterate y from 1970 to year-1, adding 365 or 366 (y%4==0) per cycle. Takes year-1970 cycles; zero cycles when year=1970.
- MONTHS: iterate m from 1 to month-1, adding days_in_month(m, leap(year)) per cycle. Takes month-1 cycles.
- COMBINE (1 cycle): unix_time <= (days + day-1)*86400 + hour*3600 + minute*60 + second, zero-extended to N. Multiplies by constants may be implemented as shift-add.
- done pulses on the edge that leaves COMBINE, with error=0 and busy falling on the same edge.
- Latency from the start-sampling edge to done high:
  - Valid input: 3 + (year-1970) + (month-1) cycles.
  - Invalid input: 2 cycles.
- error holds its value until the next done.
- Maximum result is 4102444799 (2099-12-31 23:59:59); no overflow is possible at N >= 32.

Optional Feature:
- Macro BCD_ENC_LOAD_PULSE_EN.
- When defined: adds output load_n (1 bit, active-low).
  - Driven low for exactly the done cycle when error=0; high otherwise and during reset.
  - Connects directly to the unix counter's load_n, with unix_time connected to its setCounter.
- When undefined: the port does not exist, and the parent derives the load from done & ~error.

Decomposition:
- Shared package clock_pkg:
  - EPOCH_YEAR=1970, YEAR_MAX=2099, SECS_PER_DAY=86400
  - 12-entry DAYS_IN_MONTH constant
  - state enum for this FSM
- One sub-module, bcd2_to_bin: 8-bit two-digit BCD to 7-bit binary plus valid flag. Instantiated 7 times: year as two digit pairs, plus the five other fields.

Test Plan:
- 1970-01-01 00:00:00, start -> done at +3 cycles, error=0, unix_time=0.
- 2000-03-01 00:00:00 -> done at +35, unix_time=951868800; busy high cycles +1..+34.
- 2024-02-29 12:34:56 -> done at +58, unix_time=1709210096; with BCD_ENC_LOAD_PULSE_EN, load_n low only in that cycle.
- 2023-02-29 00:00:00 after previous case -> done at +2, error=1, unix_time stays 1709210096. Repeat with minute_bcd_in=8'h6A and with hour=8'h24 -> same error response.
- 2099-12-31 23:59:59 -> done at +143, unix_time=4102444799; a second start pulse at +10 is ignored, with exactly one done.
- Run case 2, drive rst_n low at +10 for one cycle -> next edge: busy=0, unix_time=0, no done afterwards; a fresh start then completes normally.
